face_match_sequencer: RTL and testbench
=======================================

Name: face_match_sequencer

Overview:
- Sequences one face-comparison job. Pulls a FRAME_LEN-word query vector and a FRAME_LEN-word candidate vector from the two host-to-FPGA FIFOs in lockstep, one element pair at a time.
- Feeds each pair to the shared floating-point multiply-accumulate core over AXI-stream a/b channels, and marks the last pair with tlast.
- Captures the final accumulated result and writes it to the FPGA-to-host FIFO.
- Sits between the Xillybus-style FIFOs and the floating-point IP, and replaces ad-hoc sequencing in the datapath top.

Parameters:
- DATA_W, 32, width of FIFO words and float operands.
- FRAME_LEN, 128, elements per vector; legal range 2..255.
- CNT_W, 8, width of the element and frame counters.

Ports:
- bus_clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_host_to_fpga_rden_1st  out  1  query FIFO read enable.
- fifo_host_to_fpga_empty_1st  in  1  query FIFO empty.
- fifo_host_to_fpga_dout_1st  in  DATA_W  query FIFO data, valid the cycle after rden.
- fifo_host_to_fpga_rden_2nd  out  1  candidate FIFO read enable.
- fifo_host_to_fpga_empty_2nd  in  1  candidate FIFO empty.
- fifo_host_to_fpga_dout_2nd  in  DATA_W  candidate FIFO data, valid the cycle after rden.
- fifo_fpga_to_host_wren  out  1  result FIFO write enable.
- fifo_fpga_to_host_full  in  1  result FIFO full.
- fifo_fpga_to_host_din  out  DATA_W  result word.
- ab_valid  out  1  s_axis_a_tvalid and s_axis_b_tvalid (shared).
- a_ready  in  1  s_axis_a_tready.
- b_ready  in  1  s_axis_b_tready.
- a_tdata  out  DATA_W  operand a.
- b_tdata  out  DATA_W  operand b.
- ab_last  out  1  s_axis_a_tlast and s_axis_b_tlast.
- result_valid  in  1  m_axis_result_tvalid.
- result_ready  out  1  m_axis_result_tready.
- result_data  in  DATA_W  m_axis_result_tdata.
- result_last  in  1  m_axis_result_tlast.
- frames_done  out  CNT_W  count of completed jobs; wraps at 2^CNT_W.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States:
  - IDLE: go to FETCH when both FIFOs are non-empty.
  - FETCH: rden_1st = rden_2nd = 1 for exactly one cycle, only when both empties are low. If either FIFO is empty, stay in FETCH with both rden low; never read just one FIFO.
  - CAPTURE: register dout_1st into a_tdata and dout_2nd into b_tdata, then go to ISSUE.
  - ISSUE: ab_valid = 1. A transfer happens only on a cycle where a_ready && b_ready. Hold valid and data stable until then. On transfer, elem_cnt increments. If elem_cnt was FRAME_LEN-1, go to DRAIN; otherwise go to FETCH.
  - DRAIN: result_ready = 1. Discard results with result_last = 0. On result_valid && result_last, latch result_data into fifo_fpga_to_host_din and go to WRITE.
  - WRITE: wren = 1 for one cycle when full is low, otherwise wait. On write, frames_done increments, elem_cnt clears, and the state returns to IDLE.
- ab_last = 1 exactly when in ISSUE with elem_cnt == FRAME_LEN-1.
- result_ready = 0 outside DRAIN, so the core back-pressures.
- rden, wren, ab_valid, ab_last and result_ready are decoded from the state register and the inputs named above. No other combinational paths.
- Throughput: 3 cycles minimum per element pair (FETCH, CAPTURE, ISSUE) with ready high and FIFOs non-empty.
- A FIFO going empty mid-frame stalls in FETCH. The job resumes from the same elem_cnt with no data loss and no duplication.
- Reset (async, any time, including mid-frame):
  - state = IDLE; all enables, ab_valid, ab_last and result_ready = 0.
  - a_tdata, b_tdata and din = 0; elem_cnt = 0, frames_done = 0.
  - Partially read frames are not recovered; the host must flush.
- Results with result_valid arriving outside DRAIN are not accepted, because ready is low.

Test Plan:
- Both FIFOs preloaded with 128 words, a_ready = b_ready = 1:
  - exactly 128 pairs in order; ab_last only on the 128th pair.
  - 128 rden pulses per FIFO; ISSUE first reached 2 cycles after leaving IDLE.
- Toggle a_ready and b_ready independently:
  - no transfer unless both are high.
  - a_tdata and b_tdata stable while ab_valid is high; pair count still 128.
- Query FIFO goes empty after 50 words for 20 cycles:
  - both rden stay low throughout.
  - element 51 is issued after the refill; sequence unbroken.
- Core returns 127 partial results, then a final 0x42C80000 with result_last:
  - only 0x42C80000 is written to the host FIFO.
  - frames_done = 1.
- fifo_fpga_to_host_full held high for 10 cycles in WRITE:
  - no wren during the full period; a single wren after full drops; din held.
- rst_n asserted low while elem_cnt = 64:
  - outputs clear immediately without a clock edge.
  - after release, the block sits in IDLE with frames_done = 0.

Source files
------------

// File: rtl/face_match_sequencer.sv
// face_match_sequencer
//   Runs one face-comparison job. It reads FRAME_LEN element pairs from the
//   query and candidate host FIFOs in lockstep. Each pair goes to the
//   floating-point multiply-accumulate core over a shared-valid AXI-stream
//   a/b channel, and the last pair carries tlast. The core's final
//   accumulated result (tlast) goes into the FPGA-to-host FIFO.
//
// Ports
//   bus_clk, rst_n                       clock, async active-low reset
//   fifo_host_to_fpga_*_1st              query FIFO (rden / empty / dout)
//   fifo_host_to_fpga_*_2nd              candidate FIFO (rden / empty / dout)
//   fifo_fpga_to_host_*                  result FIFO (wren / full / din)
//   ab_valid, a_ready, b_ready           shared operand valid, per-channel ready
//   a_tdata, b_tdata, ab_last            operands and last-pair marker
//   result_valid/ready/data/last         accumulator result stream
//   frames_done                          completed job counter (wraps)
//   busy                                 high whenever not idle
module face_match_sequencer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 128,
    parameter int CNT_W     = 8
) (
    input  logic              bus_clk,
    input  logic              rst_n,
    output logic              fifo_host_to_fpga_rden_1st,
    input  logic              fifo_host_to_fpga_empty_1st,
    input  logic [DATA_W-1:0] fifo_host_to_fpga_dout_1st,
    output logic              fifo_host_to_fpga_rden_2nd,
    input  logic              fifo_host_to_fpga_empty_2nd,
    input  logic [DATA_W-1:0] fifo_host_to_fpga_dout_2nd,
    output logic              fifo_fpga_to_host_wren,
    input  logic              fifo_fpga_to_host_full,
    output logic [DATA_W-1:0] fifo_fpga_to_host_din,
    output logic              ab_valid,
    input  logic              a_ready,
    input  logic              b_ready,
    output logic [DATA_W-1:0] a_tdata,
    output logic [DATA_W-1:0] b_tdata,
    output logic              ab_last,
    input  logic              result_valid,
    output logic              result_ready,
    input  logic [DATA_W-1:0] result_data,
    input  logic              result_last,
    output logic [CNT_W-1:0]  frames_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0]   frames_done_q, frames_done_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  din_q, din_d;

    logic both_avail;
    logic fetch_go;
    logic xfer;
    logic is_last;

    assign both_avail = !fifo_host_to_fpga_empty_1st && !fifo_host_to_fpga_empty_2nd;
    // Both FIFOs are read together or not at all, so the pair stays aligned.
    assign fetch_go   = (state_q == S_FETCH) && both_avail;
    assign xfer       = (state_q == S_ISSUE) && a_ready && b_ready;
    assign is_last    = (elem_cnt_q == LAST_IDX);

    assign fifo_host_to_fpga_rden_1st = fetch_go;
    assign fifo_host_to_fpga_rden_2nd = fetch_go;
    assign fifo_fpga_to_host_wren     = (state_q == S_WRITE) && !fifo_fpga_to_host_full;
    assign fifo_fpga_to_host_din      = din_q;
    assign ab_valid                   = (state_q == S_ISSUE);
    assign ab_last                    = (state_q == S_ISSUE) && is_last;
    assign result_ready               = (state_q == S_DRAIN);
    assign a_tdata                    = a_q;
    assign b_tdata                    = b_q;
    assign frames_done                = frames_done_q;
    assign busy                       = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        frames_done_d = frames_done_q;
        a_d           = a_q;
        b_d           = b_q;
        din_d         = din_q;
        unique case (state_q)
            S_IDLE: begin
                if (both_avail) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (both_avail) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // FIFO data appears the cycle after rden.
                a_d     = fifo_host_to_fpga_dout_1st;
                b_d     = fifo_host_to_fpga_dout_2nd;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (xfer) begin
                    elem_cnt_d = elem_cnt_q + CNT_W'(1);
                    state_d    = is_last ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                // Partial sums (no tlast) are accepted and dropped.
                if (result_valid && result_last) begin
                    din_d   = result_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!fifo_fpga_to_host_full) begin
                    frames_done_d = frames_done_q + CNT_W'(1);
                    elem_cnt_d    = '0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            elem_cnt_q    <= '0;
            frames_done_q <= '0;
            a_q           <= '0;
            b_q           <= '0;
            din_q         <= '0;
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            frames_done_q <= frames_done_d;
            a_q           <= a_d;
            b_q           <= b_d;
            din_q         <= din_d;
        end
    end

endmodule

// File: tb/tb_face_match_sequencer.sv
// tb_face_match_sequencer
//   Directed bench for face_match_sequencer. It models the host FIFOs,
//   the accumulator core and the result FIFO. Expected pairs and results
//   are queued when stimulus is loaded and compared when the DUT emits them.
module tb_face_match_sequencer;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 128;
    localparam int CNT_W     = 8;

    logic              bus_clk;
    logic              rst_n;
    logic              rden1, rden2, empty1, empty2;
    logic [DATA_W-1:0] dout1, dout2;
    logic              wren, full;
    logic [DATA_W-1:0] din;
    logic              ab_valid, a_ready, b_ready, ab_last;
    logic [DATA_W-1:0] a_tdata, b_tdata;
    logic              result_valid, result_ready, result_last;
    logic [DATA_W-1:0] result_data;
    logic [CNT_W-1:0]  frames_done;
    logic              busy;

    face_match_sequencer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .bus_clk                     (bus_clk),
        .rst_n                       (rst_n),
        .fifo_host_to_fpga_rden_1st  (rden1),
        .fifo_host_to_fpga_empty_1st (empty1),
        .fifo_host_to_fpga_dout_1st  (dout1),
        .fifo_host_to_fpga_rden_2nd  (rden2),
        .fifo_host_to_fpga_empty_2nd (empty2),
        .fifo_host_to_fpga_dout_2nd  (dout2),
        .fifo_fpga_to_host_wren      (wren),
        .fifo_fpga_to_host_full      (full),
        .fifo_fpga_to_host_din       (din),
        .ab_valid                    (ab_valid),
        .a_ready                     (a_ready),
        .b_ready                     (b_ready),
        .a_tdata                     (a_tdata),
        .b_tdata                     (b_tdata),
        .ab_last                     (ab_last),
        .result_valid                (result_valid),
        .result_ready                (result_ready),
        .result_data                 (result_data),
        .result_last                 (result_last),
        .frames_done                 (frames_done),
        .busy                        (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q1[$], q2[$];
    logic [DATA_W-1:0] exp_a[$], exp_b[$], exp_res[$];
    logic              exp_last[$];
    logic [DATA_W-1:0] core_d[$];
    logic              core_l[$];
    logic [DATA_W-1:0] final_val;
    logic              rdy_rand;

    int pair_cnt = 0;
    int rd1_cnt  = 0;
    int rd2_cnt  = 0;
    int wr_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    // Host FIFO models: a read at an edge presents data just after that edge.
    initial begin
        logic r1, r2;
        dout1 = '0; dout2 = '0; empty1 = 1'b1; empty2 = 1'b1;
        forever begin
            @(negedge bus_clk);
            r1 = rden1; r2 = rden2;
            @(posedge bus_clk); #1;
            if (r1 && q1.size() > 0) dout1 = q1.pop_front();
            if (r2 && q2.size() > 0) dout2 = q2.pop_front();
            empty1 = (q1.size() == 0);
            empty2 = (q2.size() == 0);
        end
    end

    // Operand ready driver.
    initial begin
        a_ready = 1'b1; b_ready = 1'b1;
        forever begin
            @(posedge bus_clk); #1;
            if (rdy_rand) begin
                a_ready = 1'($urandom_range(0, 1));
                b_ready = 1'($urandom_range(0, 1));
            end else begin
                a_ready = 1'b1; b_ready = 1'b1;
            end
        end
    end

    // Accumulator model: one result per accepted pair, the last one tagged.
    initial begin
        logic xab, take, lst;
        result_valid = 1'b0; result_data = '0; result_last = 1'b0;
        forever begin
            @(negedge bus_clk);
            xab  = rst_n && ab_valid && a_ready && b_ready;
            take = rst_n && result_valid && result_ready;
            lst  = ab_last;
            @(posedge bus_clk); #1;
            if (!rst_n) begin
                core_d.delete(); core_l.delete();
            end else begin
                if (take && core_d.size() > 0) begin
                    void'(core_d.pop_front()); void'(core_l.pop_front());
                end
                if (xab) begin
                    core_d.push_back(lst ? final_val : 32'h3F80_0000 + 32'(core_d.size()));
                    core_l.push_back(lst);
                end
            end
            result_valid = (core_d.size() > 0);
            result_data  = (core_d.size() > 0) ? core_d[0] : '0;
            result_last  = (core_l.size() > 0) ? core_l[0] : 1'b0;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic              hold;
        logic [DATA_W-1:0] pa, pb;
        hold = 1'b0; pa = '0; pb = '0;
        forever begin
            @(negedge bus_clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (rden1 || rden2) begin
                    rd1_cnt += int'(rden1);
                    rd2_cnt += int'(rden2);
                    check("rden_lockstep", 32'(rden1), 32'(rden2));
                end
                if (ab_valid && hold) begin
                    check("a_stable", a_tdata, pa);
                    check("b_stable", b_tdata, pb);
                end
                if (ab_valid && a_ready && b_ready) begin
                    pair_cnt++;
                    if (exp_a.size() == 0) begin
                        check("unexpected_pair", 32'd1, 32'd0);
                    end else begin
                        check("pair_a", a_tdata, exp_a.pop_front());
                        check("pair_b", b_tdata, exp_b.pop_front());
                        check("pair_last", 32'(ab_last), 32'(exp_last.pop_front()));
                    end
                    hold = 1'b0;
                end else begin
                    hold = ab_valid;
                end
                pa = a_tdata; pb = b_tdata;
                if (wren) begin
                    wr_cnt++;
                    if (exp_res.size() == 0) check("unexpected_wren", 32'd1, 32'd0);
                    else check("result_din", din, exp_res.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge bus_clk); #1;
    endtask

    function automatic logic [DATA_W-1:0] word_a(input int f, input int i);
        return {8'(f), 8'hA0, 16'(i)};
    endfunction

    function automatic logic [DATA_W-1:0] word_b(input int f, input int i);
        return {8'(f), 8'hB0, 16'(i)};
    endfunction

    task automatic load_frame(input int f, input int n1, input logic [DATA_W-1:0] fin);
        for (int i = 0; i < FRAME_LEN; i++) begin
            exp_a.push_back(word_a(f, i));
            exp_b.push_back(word_b(f, i));
            exp_last.push_back(i == FRAME_LEN - 1);
            q2.push_back(word_b(f, i));
            if (i < n1) q1.push_back(word_a(f, i));
        end
        exp_res.push_back(fin);
        final_val = fin;
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge bus_clk);
            if (int'(frames_done) == target) begin ok = 1'b1; break; end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int bp, br1, br2, bw, n;
        bit seen;
        rst_n = 1'b0; full = 1'b0; rdy_rand = 1'b0; final_val = '0;

        // Reset state
        repeat (3) @(negedge bus_clk);
        check("rst_ctrl", {rden1, rden2, wren, ab_valid, ab_last, result_ready, busy}, 32'd0);
        check("rst_data", a_tdata | b_tdata | din, 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge bus_clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        // Frame 1: preloaded FIFOs, ready always high
        tick();
        bp = pair_cnt; br1 = rd1_cnt; br2 = rd2_cnt; bw = wr_cnt;
        load_frame(1, FRAME_LEN, 32'h42C8_0000);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge bus_clk);
            if (busy) begin seen = 1'b1; break; end
        end
        check("leave_idle", 32'(seen), 32'd1);
        n = 0;
        while (!ab_valid && n < 20) begin @(negedge bus_clk); n++; end
        check("issue_latency", 32'(n), 32'd2);
        wait_frames("frame1_done", 1, 5000);
        check("f1_pairs", 32'(pair_cnt - bp), 32'(FRAME_LEN));
        check("f1_rden1", 32'(rd1_cnt - br1), 32'(FRAME_LEN));
        check("f1_rden2", 32'(rd2_cnt - br2), 32'(FRAME_LEN));
        check("f1_writes", 32'(wr_cnt - bw), 32'd1);
        check("f1_frames", 32'(frames_done), 32'd1);

        // Frame 2: independent random readies
        tick();
        rdy_rand = 1'b1;
        bp = pair_cnt;
        load_frame(2, FRAME_LEN, 32'h4120_0002);
        wait_frames("frame2_done", 2, 8000);
        rdy_rand = 1'b0;
        check("f2_pairs", 32'(pair_cnt - bp), 32'(FRAME_LEN));

        // Frame 3: query FIFO runs dry after 50 words for 20 cycles
        tick();
        bp = pair_cnt; br1 = rd1_cnt;
        load_frame(3, 50, 32'h4120_0003);
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge bus_clk);
            if (rd1_cnt - br1 == 50) begin seen = 1'b1; break; end
        end
        check("stall_reached", 32'(seen), 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge bus_clk);
            check("stall_rden", {30'd0, rden1, rden2}, 32'd0);
        end
        check("stall_pairs", 32'(pair_cnt - bp), 32'd50);
        check("stall_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 50; i < FRAME_LEN; i++) q1.push_back(word_a(3, i));
        wait_frames("frame3_done", 3, 5000);
        check("f3_pairs", 32'(pair_cnt - bp), 32'(FRAME_LEN));
        check("f3_rden1", 32'(rd1_cnt - br1), 32'(FRAME_LEN));

        // Frame 4: result FIFO full for 10 cycles in WRITE
        tick();
        full = 1'b1;
        bw = wr_cnt;
        load_frame(4, FRAME_LEN, 32'h4120_0004);
        seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge bus_clk);
            if (din === 32'h4120_0004) begin seen = 1'b1; break; end
        end
        check("f4_latched", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("full_no_wren", 32'(wren), 32'd0);
            check("full_din_hold", din, 32'h4120_0004);
            @(negedge bus_clk);
        end
        tick();
        full = 1'b0;
        wait_frames("frame4_done", 4, 100);
        check("f4_writes", 32'(wr_cnt - bw), 32'd1);

        // Frame 5: asynchronous reset at elem_cnt = 64
        tick();
        bp = pair_cnt;
        load_frame(5, FRAME_LEN, 32'h4120_0005);
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge bus_clk);
            if (pair_cnt - bp == 64) begin seen = 1'b1; break; end
        end
        check("mid_frame_reached", 32'(seen), 32'd1);
        #3;
        rst_n = 1'b0;
        q1.delete(); q2.delete(); exp_a.delete(); exp_b.delete();
        exp_last.delete(); exp_res.delete(); core_d.delete(); core_l.delete();
        #1;
        check("async_rst_ctrl", {rden1, rden2, wren, ab_valid, ab_last, result_ready, busy}, 32'd0);
        check("async_rst_a", a_tdata, 32'd0);
        check("async_rst_b", b_tdata, 32'd0);
        check("async_rst_frames", 32'(frames_done), 32'd0);
        repeat (3) @(negedge bus_clk);
        rst_n = 1'b1;
        repeat (4) @(negedge bus_clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_frames", 32'(frames_done), 32'd0);
        check("post_rst_din", din, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
